step_motor_drv: RTL and testbench

- Responder end of the motor command interface that the position controllers drive.
- Accepts start, stop and remaining-step-modify commands, and generates step/direction drive to one stepper axis.
- Maintains the absolute step position.
- Reports running state, position and synchronized zero/terminal limit sensor status back to the controller.
- One instance per motor axis, between the controller and the board-level motor driver pins.

---
 rtl/step_motor_pkg.sv | 12 +
 rtl/sig_sync.sv | 23 ++
 rtl/step_motor_drv.sv | 225 ++++++++++++++++++++++
 tb/tb_step_motor_drv.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_motor_pkg.sv
// step_motor_pkg: shared types and constants
// for the stepper axis driver
package step_motor_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int C_MIN_SPEED = 2;

endpackage

// File: rtl/sig_sync.sv
// sig_sync: two-flop synchronizer for
// asynchronous sensor inputs
module sig_sync (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  // capture then settle the async input
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_motor_drv.sv
// step_motor_drv: stepper axis responder
// step/dir generation, position, limit sync
module step_motor_drv
  import step_motor_pkg::*;
#(
  parameter int C_STEP_NUMBER_WIDTH = 32,
  parameter int C_SPEED_DATA_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           s_sel,
  input  logic                           s_start,
  input  logic                           s_stop,
  input  logic [C_SPEED_DATA_WIDTH-1:0]  s_speed,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] s_step,
  input  logic                           s_dir,
  input  logic                           s_mod_remain,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] s_new_remain,
  output logic                           s_state,
  output logic [C_STEP_NUMBER_WIDTH-1:0] s_position,
  output logic                           s_zpsign,
  output logic                           s_tpsign,
  input  logic                           zpd,
  input  logic                           tpd,
  output logic                           o_drive,
  output logic                           o_dir,
  output logic                           o_xen
);

  localparam int SW = C_SPEED_DATA_WIDTH;
  localparam int NW = C_STEP_NUMBER_WIDTH;

  state_t state;
  state_t state_nx;

  logic [SW-1:0] spd;
  logic [SW-1:0] spd_in;
  logic [SW-1:0] pcnt;
  logic [NW-1:0] remain;
  logic [NW-1:0] pos;

  logic cont;
  logic dir;
  logic stop_pend;
  logic drive;
  logic xen;
  logic zsig;
  logic tsig;

  logic go;
  logic fire;
  logic quit;
  logic at_bnd;
  logic halt;
  logic zero_hit;
  logic mod_hit;
  logic running;

  sig_sync u_zsync (
    .clk    (clk),
    .resetn (resetn),
    .d      (zpd),
    .q      (zsig)
  );

  sig_sync u_tsync (
    .clk    (clk),
    .resetn (resetn),
    .d      (tpd),
    .q      (tsig)
  );

  // Periods shorter than two cycles cannot
  // hold a high and a low phase, so clamp.
  assign spd_in = (s_speed < SW'(C_MIN_SPEED))
                ? SW'(C_MIN_SPEED)
                : s_speed;

  assign running  = (state == ST_RUN);
  assign at_bnd   = (pcnt == '0);
  assign zero_hit = dir & zsig;
  assign mod_hit  = s_mod_remain & ~s_stop;

  assign halt = stop_pend
              | (~cont & (remain == '0))
              | zero_hit
              | (~dir & tsig);

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state and boundary decisions
  always_comb begin
    state_nx = state;
    go       = 1'b0;
    fire     = 1'b0;
    quit     = 1'b0;
    if (!s_sel) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (s_start && !s_stop) begin
            state_nx = ST_RUN;
            go       = 1'b1;
          end
        end
        ST_RUN: begin
          if (at_bnd) begin
            if (halt) begin
              state_nx = ST_IDLE;
              quit     = 1'b1;
            end else begin
              fire = 1'b1;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // latch speed and direction at start
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spd <= '0;
      dir <= 1'b0;
    end else if (go) begin
      spd <= spd_in;
      dir <= s_dir;
    end
  end

  // remaining steps; a modify overrides
  // the decrement of the same boundary
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      remain <= '0;
      cont   <= 1'b0;
    end else if (go) begin
      remain <= s_step;
      cont   <= (s_step == '0);
    end else if (running && s_sel) begin
      if (mod_hit) begin
        remain <= s_new_remain;
        cont   <= 1'b0;
      end else if (fire && !cont) begin
        remain <= remain - 1'b1;
      end
    end
  end

  // stop request held until next boundary
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stop_pend <= 1'b0;
    end else if (!s_sel || go) begin
      stop_pend <= 1'b0;
    end else if (running && s_stop) begin
      stop_pend <= 1'b1;
    end
  end

  // period counter and step pulse shaping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcnt  <= '0;
      drive <= 1'b0;
    end else if (!s_sel || go || quit) begin
      pcnt  <= '0;
      drive <= 1'b0;
    end else if (fire) begin
      pcnt  <= SW'(1);
      drive <= 1'b1;
    end else if (running) begin
      if (pcnt == (spd >> 1)) begin
        drive <= 1'b0;
      end
      if (pcnt == spd - 1'b1) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // absolute position, zeroed on home exit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos <= '0;
    end else if (quit && zero_hit) begin
      pos <= '0;
    end else if (fire) begin
      if (dir) begin
        pos <= pos - 1'b1;
      end else begin
        pos <= pos + 1'b1;
      end
    end
  end

  // driver enable tracks the axis select
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      xen <= 1'b0;
    end else begin
      xen <= s_sel;
    end
  end

  assign s_state    = running;
  assign s_position = pos;
  assign s_zpsign   = zsig;
  assign s_tpsign   = tsig;
  assign o_drive    = drive;
  assign o_dir      = dir;
  assign o_xen      = xen;

endmodule

// File: tb/tb_step_motor_drv.sv
// tb_step_motor_drv: scoreboard bench with an
// arithmetic run model for step_motor_drv
module tb_step_motor_drv;

  localparam int T_NONE = 0;
  localparam int T_STOP = 1;
  localparam int T_MOD  = 2;
  localparam int T_SEN  = 3;

  localparam int E_UP   = 0;
  localparam int E_RISE = 1;
  localparam int E_DN   = 2;

  typedef struct {
    int          kind;
    longint      cyc;
    logic [31:0] pos;
    int          hi;
    logic        dir;
  } ev_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_sel = 1'b0;
  logic        s_start = 1'b0;
  logic        s_stop = 1'b0;
  logic [31:0] s_speed = '0;
  logic [31:0] s_step = '0;
  logic        s_dir = 1'b0;
  logic        s_mod_remain = 1'b0;
  logic [31:0] s_new_remain = '0;
  logic        s_state;
  logic [31:0] s_position;
  logic        s_zpsign;
  logic        s_tpsign;
  logic        zpd = 1'b0;
  logic        tpd = 1'b0;
  logic        o_drive;
  logic        o_dir;
  logic        o_xen;

  int          n_chk = 0;
  int          n_fail = 0;
  longint      cyc = 0;
  bit          mon_en = 1'b0;
  ev_t         q[$];
  logic [31:0] mpos = '0;

  logic        pd = 1'b0;
  logic        ps = 1'b0;
  longint      rise_c = 0;
  int          hi_exp = 0;

  step_motor_drv #(
    .C_STEP_NUMBER_WIDTH (32),
    .C_SPEED_DATA_WIDTH  (32)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .s_sel        (s_sel),
    .s_start      (s_start),
    .s_stop       (s_stop),
    .s_speed      (s_speed),
    .s_step       (s_step),
    .s_dir        (s_dir),
    .s_mod_remain (s_mod_remain),
    .s_new_remain (s_new_remain),
    .s_state      (s_state),
    .s_position   (s_position),
    .s_zpsign     (s_zpsign),
    .s_tpsign     (s_tpsign),
    .zpd          (zpd),
    .tpd          (tpd),
    .o_drive      (o_drive),
    .o_dir        (o_dir),
    .o_xen        (o_xen)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] moved(
    input logic [31:0] p, input bit dr, input int n);
    return dr ? p - 32'(n) : p + 32'(n);
  endfunction

  task automatic pop_ev(input int kind);
    ev_t e;
    chk("event_expected", 64'(q.size() != 0), 64'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("event_kind", 64'(e.kind), 64'(kind));
      chk("event_cycle", 64'(cyc), 64'(e.cyc));
      if (kind != E_UP) begin
        chk("event_position", 64'(s_position), 64'(e.pos));
      end
      if (kind == E_RISE) begin
        chk("step_dir", 64'(o_dir), 64'(e.dir));
        rise_c = cyc;
        hi_exp = e.hi;
      end
    end
  endtask

  // monitor: compare DUT edges against the queue
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_drive && !pd) begin
        pop_ev(E_RISE);
      end
      if (!o_drive && pd) begin
        chk("pulse_high_time", 64'(cyc - rise_c), 64'(hi_exp));
      end
      if (s_state && !ps) begin
        pop_ev(E_UP);
      end
      if (!s_state && ps) begin
        pop_ev(E_DN);
      end
    end
    pd = o_drive;
    ps = s_state;
  end

  // One run: model the outcome arithmetically,
  // queue the expected events, then drive it.
  task automatic do_run(input int spd, input int stp,
                        input bit dr, input int term,
                        input int d, input int r,
                        input bit garb);
    int     P;
    int     K;
    int     F;
    int     g;
    bit     zc;
    longint N;
    logic [31:0] p0;
    ev_t    e;
    P  = (spd < 2) ? 2 : spd;
    zc = 1'b0;
    K  = stp;
    g  = garb ? $urandom_range(1, P) : -1;
    case (term)
      T_STOP: begin
        F = (d - 1) / P + 1;
        K = (stp != 0 && stp < F) ? stp : F;
      end
      T_MOD: K = (d - 1) / P + 1 + r;
      T_SEN: begin
        F  = d / P + 1;
        K  = (stp != 0 && stp < F) ? stp : F;
        zc = dr && (stp == 0 || F <= stp);
      end
      default: K = stp;
    endcase
    N  = cyc;
    p0 = mpos;
    e = '{E_UP, N + 1, p0, 0, dr};
    q.push_back(e);
    for (int k = 0; k < K; k++) begin
      e = '{E_RISE, N + 2 + longint'(k) * P,
            moved(p0, dr, k + 1), P / 2, dr};
      q.push_back(e);
    end
    mpos = zc ? 32'd0 : moved(p0, dr, K);
    e = '{E_DN, N + 2 + longint'(K) * P, mpos, 0, dr};
    q.push_back(e);
    for (int c = 0; c <= K * P + 3; c++) begin
      s_start      = (c == 0) || (c == g);
      s_stop       = (term == T_STOP) && (c == d);
      s_mod_remain = (term == T_MOD) && (c == d);
      s_new_remain = s_mod_remain ? 32'(r) : $urandom;
      s_speed      = (c == 0) ? 32'(spd) : $urandom_range(1, 40);
      s_step       = (c == 0) ? 32'(stp) : $urandom_range(0, 9);
      s_dir        = (c == 0) ? dr : 1'($urandom);
      if (term == T_SEN && c == d) begin
        if (dr) zpd = 1'b1;
        else    tpd = 1'b1;
      end
      if (term == T_SEN && c == d + 1) begin
        chk("sensor_sync_lat1",
            64'(dr ? s_zpsign : s_tpsign), 64'd0);
      end
      if (term == T_SEN && c == d + 2) begin
        chk("sensor_sync_lat2",
            64'(dr ? s_zpsign : s_tpsign), 64'd1);
      end
      step_cyc();
    end
    s_start      = 1'b0;
    s_stop       = 1'b0;
    s_mod_remain = 1'b0;
    zpd          = 1'b0;
    tpd          = 1'b0;
    repeat (3) step_cyc();
    chk("run_drained", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  initial begin
    int spd;
    int stp;
    int term;
    int lim;
    int P;
    bit dr;
    longint N;
    ev_t e;

    zpd = 1'b1;
    tpd = 1'b1;
    #23;
    chk("rst_state",    64'(s_state),    64'd0);
    chk("rst_position", 64'(s_position), 64'd0);
    chk("rst_drive",    64'(o_drive),    64'd0);
    chk("rst_dir",      64'(o_dir),      64'd0);
    chk("rst_xen",      64'(o_xen),      64'd0);
    chk("rst_zpsign",   64'(s_zpsign),   64'd0);
    chk("rst_tpsign",   64'(s_tpsign),   64'd0);
    zpd    = 1'b0;
    tpd    = 1'b0;
    resetn = 1'b1;
    s_sel  = 1'b1;
    step_cyc();
    step_cyc();
    chk("xen_follows_sel", 64'(o_xen), 64'd1);
    repeat (3) step_cyc();
    mon_en = 1'b1;

    do_run(10, 3, 1'b0, T_NONE, 0, 0, 1'b0);
    do_run(10, 0, 1'b0, T_MOD, 45, 2, 1'b1);
    do_run(20, 0, 1'b0, T_STOP, 65, 0, 1'b1);
    do_run(2, 86, 1'b0, T_NONE, 0, 0, 1'b0);
    chk("preset_position", 64'(s_position), 64'd100);
    do_run(10, 50, 1'b1, T_SEN, 53, 0, 1'b0);
    chk("home_position", 64'(s_position), 64'd0);
    do_run(1, 4, 1'b1, T_NONE, 0, 0, 1'b1);

    // select drop in the middle of a pulse
    N = cyc;
    e = '{E_UP, N + 1, mpos, 0, 1'b0};
    q.push_back(e);
    e = '{E_RISE, N + 2, mpos + 32'd1, 3, 1'b0};
    q.push_back(e);
    e = '{E_DN, N + 5, mpos + 32'd1, 0, 1'b0};
    q.push_back(e);
    mpos = mpos + 32'd1;
    s_speed = 32'd8;
    s_step  = 32'd0;
    s_dir   = 1'b0;
    s_start = 1'b1;
    step_cyc();
    s_start = 1'b0;
    repeat (3) step_cyc();
    s_sel = 1'b0;
    step_cyc();
    chk("seldrop_xen",   64'(o_xen),   64'd0);
    chk("seldrop_drive", 64'(o_drive), 64'd0);
    chk("seldrop_state", 64'(s_state), 64'd0);
    s_sel = 1'b1;
    repeat (4) step_cyc();
    chk("seldrop_pos", 64'(s_position), 64'(mpos));
    chk("seldrop_drained", 64'(q.size()), 64'd0);

    for (int i = 0; i < 30; i++) begin
      spd  = $urandom_range(1, 12);
      stp  = $urandom_range(0, 6);
      dr   = 1'($urandom);
      term = $urandom_range(0, 3);
      if (stp == 0 && term == T_NONE) term = T_STOP;
      P   = (spd < 2) ? 2 : spd;
      lim = (stp != 0) ? stp * P : 6 * P;
      do_run(spd, stp, dr, term, $urandom_range(1, lim),
             $urandom_range(0, 3), 1'($urandom));
    end

    // asynchronous reset in the middle of a pulse
    mon_en = 1'b0;
    q.delete();
    zpd     = 1'b1;
    s_speed = 32'd10;
    s_step  = 32'd0;
    s_dir   = 1'b0;
    s_start = 1'b1;
    step_cyc();
    s_start = 1'b0;
    for (int i = 0; i < 40 && !o_drive; i++) step_cyc();
    chk("arst_pulse_seen", 64'(o_drive), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_state",    64'(s_state),    64'd0);
    chk("arst_position", 64'(s_position), 64'd0);
    chk("arst_drive",    64'(o_drive),    64'd0);
    chk("arst_dir",      64'(o_dir),      64'd0);
    chk("arst_xen",      64'(o_xen),      64'd0);
    chk("arst_zpsign",   64'(s_zpsign),   64'd0);
    chk("arst_tpsign",   64'(s_tpsign),   64'd0);
    zpd = 1'b0;
    step_cyc();
    #2;
    resetn = 1'b1;
    step_cyc();
    step_cyc();
    mpos   = '0;
    mon_en = 1'b1;
    s_speed = 32'd4;
    s_step  = 32'd2;
    s_start = 1'b1;
    s_stop  = 1'b1;
    step_cyc();
    s_start = 1'b0;
    s_stop  = 1'b0;
    repeat (6) step_cyc();
    chk("start_with_stop_state", 64'(s_state),    64'd0);
    chk("start_with_stop_pos",   64'(s_position), 64'd0);
    chk("post_reset_xen",        64'(o_xen),      64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
